calc_digit_entry: RTL and testbench
===================================

Name: calc_digit_entry

Overview:
- Consumes decoded keystrokes from the PS/2 scan stage (ASCII '0'-'9', Enter 0x0A, unknown 0xFE) and builds two decimal operands for the calculator datapath.
- Accumulates digits into a binary value and a BCD display shadow.
- Enter commits operand A, then operand B. The operand pair is then offered downstream on a valid/ready handshake.

Parameters:
- MAX_DIGITS, 4, maximum decimal digits per operand.
- WIDTH, 16, operand width in bits. Must satisfy 2^WIDTH > 10^MAX_DIGITS - 1; checked at elaboration.
- KEY_LAT, 1, cycles between key_strobe and key_ascii being valid. The scan stage registers ASCII one cycle after its strobe.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- key_ascii  in  8  ASCII code from scan stage
- key_strobe  in  1  one-cycle pulse per key release from scan stage
- ops_ready  in  1  downstream accepts operand pair
- op_a  out  WIDTH  committed operand A
- op_b  out  WIDTH  committed operand B
- ops_valid  out  1  operand pair available
- disp_bcd  out  4*MAX_DIGITS  digits of the operand being entered; nibble 0 is least significant
- digit_cnt  out  $clog2(MAX_DIGITS+1)  digits entered in the current operand
- entry_sel  out  1  0 = entering A, 1 = entering B
- ovf_pulse  out  1  one-cycle pulse when a digit is rejected because the operand is full

Behaviour:
- Reset: clk edge with rst_n=0. Applies mid-operation too and discards any partial entry or pending pair.
  - Outputs: op_a=0, op_b=0, ops_valid=0, disp_bcd=0, digit_cnt=0, entry_sel=0, ovf_pulse=0.
  - Internal: accumulator=0, state=ENTER_A, strobe delay line cleared.
- Key alignment: key_strobe is delayed KEY_LAT cycles to form key_evt. key_ascii is sampled on key_evt. A strobe arriving inside the delay window is also delayed, so no strobe is lost.
- Key classes:
  - digit: 0x30-0x39, value = code-0x30.
  - enter: 0x0A.
  - anything else (including 0xFE) is ignored with no state change.
- States: ENTER_A, ENTER_B, PRESENT.
- ENTER_A / ENTER_B, digit key:
  - If digit_cnt < MAX_DIGITS:
    - acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d, truncated to WIDTH.
    - disp_bcd shifts left one nibble with d inserted at nibble 0.
    - digit_cnt increments.
    - All three update on the cycle after key_evt.
  - Otherwise: no change, and ovf_pulse=1 for that one cycle.
  - Leading zeros are counted as digits.
- ENTER_A, enter key:
  - If digit_cnt==0: ignored.
  - Else: op_a<=acc; acc, disp_bcd, digit_cnt cleared; entry_sel<=1; go to ENTER_B.
- ENTER_B, enter key:
  - If digit_cnt==0: ignored.
  - Else: op_b<=acc; clear the entry registers; ops_valid<=1; go to PRESENT.
  - entry_sel stays 1 while in PRESENT.
- PRESENT:
  - ops_valid held high; op_a and op_b stable.
  - All keys dropped, with no ovf_pulse.
  - Transfer completes on a cycle with ops_valid && ops_ready. The next cycle has ops_valid=0, entry_sel=0, state=ENTER_A.
  - ops_ready is ignored outside PRESENT.
- Latency: key_evt to register update is 1 cycle, so key_strobe to visible update is KEY_LAT+1 cycles.
- Only one key_evt can occur per cycle. PS/2 byte spacing is >> KEY_LAT, and the block does not buffer keys.

Decomposition:
- Package calc_pkg:
  - ASCII constants: KEY_ZERO=8'h30, KEY_NINE=8'h39, KEY_ENTER=8'h0A, KEY_NONE=8'hFE.
  - Entry state enum: ENTER_A, ENTER_B, PRESENT.
  - Helper function is_digit.
- One sub-module, calc_dec_accum: accumulator, BCD shadow and digit counter.
  - Inputs: load_digit, digit, clear.
  - Outputs: acc, bcd, cnt, full.
- The top holds the strobe delay, the key classifier, the FSM and the handshake.

Test Plan:
- Reset, then strobe '1','2','3' (0x31,0x32,0x33), Enter → entry_sel=1, digit_cnt=0.
- Then strobe '4','5', Enter → op_a=123, op_b=45, ops_valid=1.
- Hold ops_ready=0 for 20 cycles → ops_valid stays 1 and op_a/op_b stay stable. Raise ops_ready → ops_valid=0 the next cycle, entry_sel=0.
- Strobe 5 digits '9','9','9','9','9' → acc=9999, disp_bcd=16'h9999, digit_cnt=4, exactly one ovf_pulse on the fifth key.
- Enter with zero digits, then 0xFE → no state change, entry_sel=0, ops_valid=0.
- While in PRESENT, strobe '7' and Enter → both dropped, op_a/op_b unchanged. Entry mid-operand (2 digits of B), rst_n=0 for one edge → all outputs 0, state ENTER_A.
- Strobe at t and key_ascii changing only at t+1 → digit value from the t+1 sample is used; disp_bcd updates at t+2.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: keystroke codes, entry states and helpers shared by the digit-entry block
package calc_pkg;
    localparam logic [7:0] KEY_ZERO  = 8'h30;
    localparam logic [7:0] KEY_NINE  = 8'h39;
    localparam logic [7:0] KEY_ENTER = 8'h0A;
    localparam logic [7:0] KEY_NONE  = 8'hFE;

    typedef enum logic [1:0] {ENTER_A, ENTER_B, PRESENT} entry_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return c >= KEY_ZERO && c <= KEY_NINE;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction
endpackage

// File: rtl/calc_digit_entry_if.sv
// calc_digit_entry_if: keystroke input, operand handshake and entry status bundle
interface calc_digit_entry_if #(
    parameter int MAX_DIGITS = 4,
    parameter int WIDTH      = 16
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    logic [7:0]              key_ascii;
    logic                    key_strobe;
    logic                    ops_ready;
    logic [WIDTH-1:0]        op_a;
    logic [WIDTH-1:0]        op_b;
    logic                    ops_valid;
    logic [4*MAX_DIGITS-1:0] disp_bcd;
    logic [CW-1:0]           digit_cnt;
    logic                    entry_sel;
    logic                    ovf_pulse;

    modport slave (
        input  key_ascii, key_strobe, ops_ready,
        output op_a, op_b, ops_valid, disp_bcd, digit_cnt, entry_sel, ovf_pulse
    );
    modport master (
        output key_ascii, key_strobe, ops_ready,
        input  op_a, op_b, ops_valid, disp_bcd, digit_cnt, entry_sel, ovf_pulse
    );
endinterface

// File: rtl/calc_dec_accum.sv
// calc_dec_accum: binary accumulator with BCD display shadow and digit counter
module calc_dec_accum #(
    parameter int MAX_DIGITS = 4,
    parameter int WIDTH      = 16,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_digit,
    input  logic [3:0]              digit,
    input  logic                    clear,
    output logic [WIDTH-1:0]        acc,
    output logic [4*MAX_DIGITS-1:0] bcd,
    output logic [CW-1:0]           cnt,
    output logic                    full
);
    logic [WIDTH-1:0]        acc_q, acc_d;
    logic [4*MAX_DIGITS-1:0] bcd_q, bcd_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    always_comb begin
        acc_d = clear ? '0 : load_digit ? (acc_q << 3) + (acc_q << 1) + WIDTH'(digit) : acc_q;
        bcd_d = clear ? '0 : load_digit ? {bcd_q[4*MAX_DIGITS-5:0], digit} : bcd_q;
        cnt_d = clear ? '0 : load_digit ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign bcd  = bcd_q;
    assign cnt  = cnt_q;
    assign full = cnt_q == CW'(MAX_DIGITS);
endmodule

// File: rtl/calc_digit_entry.sv
// calc_digit_entry: aligns scan-stage keystrokes, builds operands A and B,
// and offers the committed pair downstream on a valid/ready handshake.
module calc_digit_entry
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int WIDTH      = 16,
    parameter int KEY_LAT    = 1
) (
    input logic                clk,
    input logic                rst_n,
    calc_digit_entry_if.slave  bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    if ((64'd1 << WIDTH) <= pow10(MAX_DIGITS) - 1) begin : g_width_check
        $error("WIDTH too small to hold MAX_DIGITS decimal digits");
    end

    entry_state_e     state_q, state_d;
    logic [KEY_LAT-1:0] dly_q;
    logic [KEY_LAT:0]   dly_in;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic             ovf_q, ovf_d;
    logic             key_evt, dig_evt, ent_evt, entering, load_digit, commit, full;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    // key_ascii trails its strobe, so the strobe is delayed to line up with the code
    assign dly_in  = {dly_q, bus.key_strobe};
    assign key_evt = dly_q[KEY_LAT-1];

    always_comb begin
        dig_evt    = key_evt && is_digit(bus.key_ascii);
        ent_evt    = key_evt && bus.key_ascii == KEY_ENTER;
        entering   = state_q != PRESENT;
        load_digit = dig_evt && entering && !full;
        ovf_d      = dig_evt && entering && full;
        commit     = ent_evt && entering && cnt != '0;
        op_a_d     = commit && state_q == ENTER_A ? acc : op_a_q;
        op_b_d     = commit && state_q == ENTER_B ? acc : op_b_q;
        state_d    = state_q;
        case (state_q)
            ENTER_A: state_d = commit ? ENTER_B : ENTER_A;
            ENTER_B: state_d = commit ? PRESENT : ENTER_B;
            PRESENT: state_d = bus.ops_ready ? ENTER_A : PRESENT;
            default: state_d = ENTER_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ENTER_A;
            dly_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_in[KEY_LAT-1:0];
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            ovf_q   <= ovf_d;
        end
    end

    calc_dec_accum #(.MAX_DIGITS(MAX_DIGITS), .WIDTH(WIDTH), .CW(CW)) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_digit (load_digit),
        .digit      (bus.key_ascii[3:0]),
        .clear      (commit),
        .acc        (acc),
        .bcd        (bus.disp_bcd),
        .cnt        (cnt),
        .full       (full)
    );

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.ops_valid = state_q == PRESENT;
    assign bus.entry_sel = state_q != ENTER_A;
    assign bus.digit_cnt = cnt;
    assign bus.ovf_pulse = ovf_q;
endmodule

// File: tb/tb_calc_digit_entry.sv
// tb_calc_digit_entry: directed keystroke sequences with hand-computed expectations
module tb_calc_digit_entry;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   ovf_cnt = 0;

    always #5 clk = ~clk;

    calc_digit_entry_if #(.MAX_DIGITS(4), .WIDTH(16)) bus ();

    calc_digit_entry #(.MAX_DIGITS(4), .WIDTH(16), .KEY_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) if (rst_n && bus.ovf_pulse) ovf_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // strobe cycle, then the code one cycle later, then settle
    task automatic key(input logic [7:0] c);
        bus.key_strobe = 1'b1;
        bus.key_ascii  = 8'h00;
        tick();
        bus.key_strobe = 1'b0;
        bus.key_ascii  = c;
        tick();
        bus.key_ascii  = 8'h00;
        tick(2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_op_a"}, 32'(bus.op_a), 32'd0);
        check({tag, "_op_b"}, 32'(bus.op_b), 32'd0);
        check({tag, "_valid"}, 32'(bus.ops_valid), 32'd0);
        check({tag, "_disp"}, 32'(bus.disp_bcd), 32'd0);
        check({tag, "_cnt"}, 32'(bus.digit_cnt), 32'd0);
        check({tag, "_sel"}, 32'(bus.entry_sel), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf_pulse), 32'd0);
    endtask

    initial begin
        bus.key_strobe = 1'b0;
        bus.key_ascii  = 8'h00;
        bus.ops_ready  = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check_zero("rst");

        key(8'h31); key(8'h32); key(8'h33);
        check("a_disp", 32'(bus.disp_bcd), 32'h0123);
        check("a_cnt", 32'(bus.digit_cnt), 32'd3);
        key(KEY_ENTER);
        check("a_sel", 32'(bus.entry_sel), 32'd1);
        check("a_cnt0", 32'(bus.digit_cnt), 32'd0);
        check("a_disp0", 32'(bus.disp_bcd), 32'd0);
        check("a_val", 32'(bus.op_a), 32'd123);
        check("a_valid", 32'(bus.ops_valid), 32'd0);

        key(8'h34); key(8'h35);
        check("b_disp", 32'(bus.disp_bcd), 32'h0045);
        key(KEY_ENTER);
        check("b_op_a", 32'(bus.op_a), 32'd123);
        check("b_op_b", 32'(bus.op_b), 32'd45);
        check("b_valid", 32'(bus.ops_valid), 32'd1);
        check("b_sel", 32'(bus.entry_sel), 32'd1);

        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", 32'(bus.ops_valid), 32'd1);
            check("hold_ab", {bus.op_a, bus.op_b}, {16'd123, 16'd45});
        end
        bus.ops_ready = 1'b1;
        tick();
        bus.ops_ready = 1'b0;
        check("xfer_valid", 32'(bus.ops_valid), 32'd0);
        check("xfer_sel", 32'(bus.entry_sel), 32'd0);

        key(KEY_ENTER);
        key(KEY_NONE);
        check("idle_sel", 32'(bus.entry_sel), 32'd0);
        check("idle_valid", 32'(bus.ops_valid), 32'd0);
        check("idle_cnt", 32'(bus.digit_cnt), 32'd0);
        check("idle_op_a", 32'(bus.op_a), 32'd123);

        ovf_cnt = 0;
        repeat (4) key(8'h39);
        check("ovf_none", 32'(ovf_cnt), 32'd0);
        key(8'h39);
        check("ovf_disp", 32'(bus.disp_bcd), 32'h9999);
        check("ovf_cnt", 32'(bus.digit_cnt), 32'd4);
        check("ovf_pulses", 32'(ovf_cnt), 32'd1);
        key(KEY_ENTER);
        check("ovf_op_a", 32'(bus.op_a), 32'd9999);
        check("ovf_sel", 32'(bus.entry_sel), 32'd1);

        key(8'h30); key(8'h36);
        check("lead0_cnt", 32'(bus.digit_cnt), 32'd2);
        key(KEY_ENTER);
        check("p_op_b", 32'(bus.op_b), 32'd6);
        check("p_valid", 32'(bus.ops_valid), 32'd1);
        key(8'h37);
        key(KEY_ENTER);
        check("drop_ab", {bus.op_a, bus.op_b}, {16'd9999, 16'd6});
        check("drop_valid", 32'(bus.ops_valid), 32'd1);
        check("drop_cnt", 32'(bus.digit_cnt), 32'd0);
        check("drop_disp", 32'(bus.disp_bcd), 32'd0);
        check("drop_ovf", 32'(ovf_cnt), 32'd1);

        bus.ops_ready = 1'b1;
        tick();
        bus.ops_ready = 1'b0;
        key(8'h38); key(KEY_ENTER);
        key(8'h31); key(8'h32);
        check("mid_disp", 32'(bus.disp_bcd), 32'h0012);
        check("mid_op_a", 32'(bus.op_a), 32'd8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("mrst");

        bus.key_strobe = 1'b1;
        bus.key_ascii  = 8'h31;
        tick();
        bus.key_strobe = 1'b0;
        bus.key_ascii  = 8'h35;
        check("align_t1", 32'(bus.disp_bcd), 32'd0);
        tick();
        bus.key_ascii  = 8'h00;
        check("align_t2", 32'(bus.disp_bcd), 32'h0005);
        check("align_cnt", 32'(bus.digit_cnt), 32'd1);
        check("align_sel", 32'(bus.entry_sel), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
